// File: rtl/demux4_stream.sv
// Registered 1-to-4 valid/ready stream distributor. Each output owns a 2-entry FIFO so a
// stalled consumer only blocks words addressed to it.
module demux4_stream #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       s_sel,
  input  logic [WIDTH-1:0] s_data,
  output logic [3:0]       m_valid,
  input  logic [3:0]       m_ready,
  output logic [WIDTH-1:0] m_data0,
  output logic [WIDTH-1:0] m_data1,
  output logic [WIDTH-1:0] m_data2,
  output logic [WIDTH-1:0] m_data3,
  output logic             busy
);

  // e0 is always the head entry; e1 is only meaningful at count 2.
  logic [1:0]       count_q [4];
  logic [1:0]       count_d [4];
  logic [WIDTH-1:0] e0_q    [4];
  logic [WIDTH-1:0] e0_d    [4];
  logic [WIDTH-1:0] e1_q    [4];
  logic [WIDTH-1:0] e1_d    [4];

  logic [3:0] full;
  logic [3:0] push;
  logic [3:0] pop;

  // Status decode; count 3 is treated as empty.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      full[i]    = (count_q[i] == 2'd2);
      m_valid[i] = (count_q[i] == 2'd1) || (count_q[i] == 2'd2);
    end
  end

  // Ready looks only at registered occupancy, so there is no m_ready -> s_ready path.
  assign s_ready = ~full[s_sel] & ~flush;
  assign busy    = |m_valid;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      push[i] = s_valid & s_ready & (s_sel == 2'(i));
      pop[i]  = m_valid[i] & m_ready[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      count_d[i] = count_q[i];
      e0_d[i]    = e0_q[i];
      e1_d[i]    = e1_q[i];
      if (flush) begin
        count_d[i] = 2'd0;
        e0_d[i]    = '0;
        e1_d[i]    = '0;
      end else begin
        unique case (count_q[i])
          2'd0: begin
            if (push[i]) begin
              count_d[i] = 2'd1;
              e0_d[i]    = s_data;
            end
          end
          2'd1: begin
            if (push[i] && pop[i]) begin
              e0_d[i] = s_data;
            end else if (push[i]) begin
              count_d[i] = 2'd2;
              e1_d[i]    = s_data;
            end else if (pop[i]) begin
              count_d[i] = 2'd0;
            end
          end
          2'd2: begin
            // Push is impossible here since s_ready is low for this output.
            if (pop[i]) begin
              count_d[i] = 2'd1;
              e0_d[i]    = e1_q[i];
            end
          end
          default: begin
            count_d[i] = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        count_q[i] <= 2'd0;
        e0_q[i]    <= '0;
        e1_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        count_q[i] <= count_d[i];
        e0_q[i]    <= e0_d[i];
        e1_q[i]    <= e1_d[i];
      end
    end
  end

  assign m_data0 = e0_q[0];
  assign m_data1 = e0_q[1];
  assign m_data2 = e0_q[2];
  assign m_data3 = e0_q[3];

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: hand vectors, directed corner sequences and random
// traffic compared against a queue-based reference model.
module tb_demux4_stream;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         s_valid;
  logic         s_ready;
  logic [1:0]   s_sel;
  logic [W-1:0] s_data;
  logic [3:0]   m_valid;
  logic [3:0]   m_ready;
  logic [W-1:0] m_data0, m_data1, m_data2, m_data3;
  logic         busy;

  demux4_stream #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data0 (m_data0),
    .m_data1 (m_data1),
    .m_data2 (m_data2),
    .m_data3 (m_data3),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one FIFO queue per output, capacity 2.
  logic [W-1:0] q [4][$];

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [3:0]  mr;
    logic        fl;
    logic        exp_rdy;
    logic [3:0]  exp_mv;
    int          chk_ch;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdat(input int i);
    case (i)
      0:       return m_data0;
      1:       return m_data1;
      2:       return m_data2;
      default: return m_data3;
    endcase
  endfunction

  // Drive one cycle, compare against the model away from the edge, then advance the model.
  task automatic cyc(input logic v, input logic [1:0] sel, input logic [31:0] d,
                     input logic [3:0] mr, input logic fl, output logic acc,
                     output logic obs_rdy, output logic [3:0] obs_mv,
                     output logic [3:0][31:0] obs_dat);
    logic       er;
    logic [3:0] emv;
    logic [3:0] pops;
    @(negedge clk);
    s_valid = v;
    s_sel   = sel;
    s_data  = d;
    m_ready = mr;
    flush   = fl;
    #1;
    er = !fl && (q[sel].size() != 2);
    for (int i = 0; i < 4; i++) emv[i] = (q[i].size() != 0);
    chk("s_ready", {31'd0, s_ready}, {31'd0, er});
    chk("m_valid", {28'd0, m_valid}, {28'd0, emv});
    chk("busy", {31'd0, busy}, {31'd0, |emv});
    for (int i = 0; i < 4; i++)
      if (emv[i]) chk($sformatf("m_data%0d", i), mdat(i), q[i][0]);
    obs_rdy = s_ready;
    obs_mv  = m_valid;
    for (int i = 0; i < 4; i++) obs_dat[i] = mdat(i);
    acc  = v && er;
    pops = emv & mr;
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < 4; i++) q[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) if (pops[i]) void'(q[i].pop_front());
      if (acc) q[sel].push_back(d);
    end
  endtask

  task automatic go(input logic v, input logic [1:0] sel, input logic [31:0] d,
                    input logic [3:0] mr, input logic fl);
    logic             a, r;
    logic [3:0]       mv;
    logic [3:0][31:0] dt;
    cyc(v, sel, d, mr, fl, a, r, mv, dt);
  endtask

  initial begin
    logic             acc, rdy, pend;
    logic [3:0]       mv;
    logic [3:0][31:0] dat;
    logic             rv, rfl;
    logic [1:0]       rsel;
    logic [31:0]      rd;
    logic [3:0]       rmr;

    //        v  sel  data   mr     fl  rdy  mv       ch  dat
    vecs[0]  = '{1, 0, 32'hA0, 4'hF, 0, 1, 4'b0000, -1, 0};
    vecs[1]  = '{1, 1, 32'hA1, 4'hF, 0, 1, 4'b0001,  0, 32'hA0};
    vecs[2]  = '{1, 2, 32'hA2, 4'hF, 0, 1, 4'b0010,  1, 32'hA1};
    vecs[3]  = '{1, 3, 32'hA3, 4'hF, 0, 1, 4'b0100,  2, 32'hA2};
    vecs[4]  = '{0, 0, 32'h0,  4'hF, 0, 1, 4'b1000,  3, 32'hA3};
    vecs[5]  = '{0, 0, 32'h0,  4'hF, 0, 1, 4'b0000, -1, 0};
    vecs[6]  = '{1, 2, 32'h11, 4'hB, 0, 1, 4'b0000, -1, 0};
    vecs[7]  = '{1, 2, 32'h22, 4'hB, 0, 1, 4'b0100,  2, 32'h11};
    vecs[8]  = '{1, 2, 32'h33, 4'hB, 0, 0, 4'b0100,  2, 32'h11};
    vecs[9]  = '{1, 2, 32'h33, 4'hF, 0, 0, 4'b0100,  2, 32'h11};
    vecs[10] = '{1, 2, 32'h33, 4'hF, 0, 1, 4'b0100,  2, 32'h22};
    vecs[11] = '{0, 2, 32'h0,  4'hF, 0, 1, 4'b0100,  2, 32'h33};
    vecs[12] = '{0, 2, 32'h0,  4'hF, 0, 1, 4'b0000, -1, 0};

    reset   = 1'b1;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_sel   = 2'd0;
    s_data  = '0;
    m_ready = 4'h0;
    #12;
    chk("reset_m_valid", {28'd0, m_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_s_ready", {31'd0, s_ready}, 32'd1);
    chk("reset_m_data0", m_data0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin routing and backpressure with one-bubble full release.
    for (int n = 0; n < 13; n++) begin
      cyc(vecs[n].v, vecs[n].sel, vecs[n].d, vecs[n].mr, vecs[n].fl, acc, rdy, mv, dat);
      chk($sformatf("vec%0d_s_ready", n), {31'd0, rdy}, {31'd0, vecs[n].exp_rdy});
      chk($sformatf("vec%0d_m_valid", n), {28'd0, mv}, {28'd0, vecs[n].exp_mv});
      if (vecs[n].chk_ch >= 0)
        chk($sformatf("vec%0d_m_data", n), dat[vecs[n].chk_ch], vecs[n].exp_dat);
    end

    // Isolation: out1 stalled full, sel 3 traffic flows every offered cycle.
    go(1, 1, 32'h100, 4'hD, 0);
    go(1, 1, 32'h101, 4'hD, 0);
    for (int n = 0; n < 6; n++) begin
      cyc(1, (n % 2 == 0) ? 2'd1 : 2'd3, 32'h300 + n, 4'hD, 0, acc, rdy, mv, dat);
      chk($sformatf("iso%0d_accept", n), {31'd0, acc}, (n % 2 == 0) ? 32'd0 : 32'd1);
    end
    for (int n = 0; n < 4; n++) go(0, 0, 0, 4'hF, 0);

    // Streaming: 16 back-to-back words to out0, consumer always ready.
    for (int n = 0; n < 17; n++) begin
      cyc(n < 16, 2'd0, n, 4'hF, 0, acc, rdy, mv, dat);
      if (n < 16) chk($sformatf("stream%0d_s_ready", n), {31'd0, rdy}, 32'd1);
      if (n > 0) chk($sformatf("stream%0d_data", n), dat[0], n - 1);
    end
    go(0, 0, 0, 4'hF, 0);

    // Flush: outputs 0 and 3 full, flushed-cycle word must vanish.
    go(1, 0, 32'hF0, 4'h0, 0);
    go(1, 0, 32'hF1, 4'h0, 0);
    go(1, 3, 32'hF3, 4'h0, 0);
    go(1, 3, 32'hF4, 4'h0, 0);
    cyc(1, 1, 32'hDEAD, 4'h0, 1, acc, rdy, mv, dat);
    chk("flush_s_ready", {31'd0, rdy}, 32'd0);
    chk("flush_pre_m_valid", {28'd0, mv}, 32'h9);
    cyc(0, 1, 0, 4'hF, 0, acc, rdy, mv, dat);
    chk("flush_post_m_valid", {28'd0, mv}, 32'd0);
    for (int n = 0; n < 3; n++) go(0, 1, 0, 4'hF, 0);

    // Asynchronous reset in mid-cycle with words buffered.
    go(1, 2, 32'h55, 4'h0, 0);
    go(1, 1, 32'h66, 4'h0, 0);
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_m_valid", {28'd0, m_valid}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_m_data1", m_data1, 32'd0);
    chk("midreset_m_data2", m_data2, 32'd0);
    for (int i = 0; i < 4; i++) q[i].delete();
    @(negedge clk);
    reset = 1'b0;
    go(0, 2, 0, 4'hF, 0);

    // Random traffic honouring the producer hold rule.
    pend = 1'b0;
    rv   = 1'b0;
    rsel = 2'd0;
    rd   = '0;
    for (int n = 0; n < 500; n++) begin
      if (!pend) begin
        rv   = ($urandom_range(0, 3) != 0);
        rsel = 2'($urandom);
        rd   = $urandom;
      end
      rmr = 4'($urandom);
      rfl = ($urandom_range(0, 31) == 0);
      cyc(rv, rsel, rd, rmr, rfl, acc, rdy, mv, dat);
      pend = rv && !acc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
